// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core and the UART receive ring.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CPU   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int DEF_RING_BASE  = 32'h0000_0300;
    localparam int DEF_RING_WORDS = 64;
    localparam int DEF_TIMEOUT    = 1024;

    localparam int LANE_W   = 8;
    localparam int LANES    = 4;
    localparam int HOLD_W   = LANE_W * (LANES - 1);
    localparam int WORD_W   = LANE_W * LANES;

endpackage

// File: rtl/dmem_arb_fifo.sv
// Packed-word FIFO with show-ahead head; a push is accepted while full when a pop happens in the same cycle.
module dmem_arb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the core (always wins) and a UART byte packer draining into a ring.
// Optional partial-word flush on receive idle is enabled with `define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int RING_BASE  = DEF_RING_BASE,
`ifdef DMEM_ARB_TIMEOUT_EN
    parameter int RING_WORDS = DEF_RING_WORDS,
    parameter int TIMEOUT    = DEF_TIMEOUT
`else
    parameter int RING_WORDS = DEF_RING_WORDS
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpu_req_i,
    input  logic                          cpu_we_i,
    input  logic [ADDR_W-1:0]             cpu_addr_i,
    input  logic [31:0]                   cpu_wdata_i,
    output logic [31:0]                   cpu_rdata_o,
    input  logic                          rx_valid_i,
    input  logic [7:0]                    rx_byte_i,
    output logic                          mem_we_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic [31:0]                   mem_rdata_i,
    output logic [$clog2(RING_WORDS)-1:0] wr_ptr_o,
    output logic                          overflow_o,
    output logic                          busy_o
);

    localparam int PTR_W = $clog2(RING_WORDS);

    arb_state_t         state_r;
    logic [1:0]         byte_cnt_r;
    logic [HOLD_W-1:0]  hold_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic               overflow_r;

    logic               full_word_s;
    logic               to_flush_s;
    logic               word_done_s;
    logic [WORD_W-1:0]  word_s;
    logic               drain_s;
    logic [ADDR_W-1:0]  ring_addr_s;
    logic [WORD_W-1:0]  fifo_head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT);

    logic [TO_W-1:0] to_cnt_r;

    assign to_flush_s = (byte_cnt_r != 2'd0) && !rx_valid_i && (to_cnt_r == TO_W'(TIMEOUT - 1));

    // Idle counter: runs only while a partial word waits and no byte arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r <= '0;
        end else if (rx_valid_i || (byte_cnt_r == 2'd0) || to_flush_s) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign to_flush_s = 1'b0;
`endif

    // A flushed partial word relies on the holding register being zeroed after every push.
    assign full_word_s = rx_valid_i && (byte_cnt_r == 2'd3);
    assign word_done_s = full_word_s || to_flush_s;
    assign word_s      = full_word_s ? {rx_byte_i, hold_r} : {8'h00, hold_r};

    // Reset gates the drain so no ring write escapes in the reset cycle.
    assign drain_s     = !cpu_req_i && !fifo_empty_s && !reset;
    assign ring_addr_s = ADDR_W'(RING_BASE) + ADDR_W'(wr_ptr_r);

    dmem_arb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (word_done_s),
        .pop   (drain_s),
        .wdata (word_s),
        .head  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Byte packer: little-endian lanes, counter wraps 3 -> 0 on the completing byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_r <= 2'd0;
            hold_r     <= '0;
        end else if (rx_valid_i) begin
            case (byte_cnt_r)
                2'd0:    hold_r[7:0]   <= rx_byte_i;
                2'd1:    hold_r[15:8]  <= rx_byte_i;
                2'd2:    hold_r[23:16] <= rx_byte_i;
                default: hold_r        <= '0;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else if (to_flush_s) begin
            byte_cnt_r <= 2'd0;
            hold_r     <= '0;
        end
    end

    // Ring write pointer and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (drain_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (word_done_s && fifo_full_s && !drain_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Arbiter state, observational only: the port mux below does not use it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else if (cpu_req_i) begin
            state_r <= CPU;
        end else if (!fifo_empty_s) begin
            state_r <= DRAIN;
        end else begin
            state_r <= IDLE;
        end
    end

    // Port mux: core first, then drain, otherwise a non-writing pass-through.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        if (cpu_req_i) begin
            mem_we_o = cpu_we_i;
        end else if (drain_s) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = ring_addr_s;
            mem_wdata_o = fifo_head_s;
        end else begin
            mem_we_o = 1'b0;
        end
    end

    assign cpu_rdata_o = mem_rdata_i;
    assign wr_ptr_o    = wr_ptr_r;
    assign overflow_o  = overflow_r;
    assign busy_o      = (byte_cnt_r != 2'd0) || !fifo_empty_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter against a queue-based model of the packer, FIFO and ring.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DEPTH = 4;
    localparam int RW    = 64;
    localparam int BASE  = 32'h0000_0300;
`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int TO    = 16;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_i, cpu_we_i;
    logic [9:0]  cpu_addr_i;
    logic [31:0] cpu_wdata_i, cpu_rdata_o;
    logic        rx_valid_i;
    logic [7:0]  rx_byte_i;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [5:0]  wr_ptr_o;
    logic        overflow_o, busy_o;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W     (10),
        .FIFO_DEPTH (DEPTH),
        .RING_BASE  (BASE),
`ifdef DMEM_ARB_TIMEOUT_EN
        .RING_WORDS (RW),
        .TIMEOUT    (TO)
`else
        .RING_WORDS (RW)
`endif
    ) dut (
        .clk(clk), .reset(reset), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
        .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .wr_ptr_o(wr_ptr_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [7:0]  m_bytes[$];
    int          m_ptr = 0;
    bit          m_ovf = 1'b0;
    int          m_idle = 0;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;

    // Port expectation from the model for the inputs currently applied.
    task automatic model_expect();
        if (!reset && !cpu_req_i && m_q.size() > 0) begin
            e_we    = 1'b1;
            e_addr  = 10'(BASE + m_ptr);
            e_wdata = m_q[0];
        end else begin
            e_we    = cpu_req_i ? cpu_we_i : 1'b0;
            e_addr  = cpu_addr_i;
            e_wdata = cpu_wdata_i;
        end
    endtask

    // Model state advance at a rising edge.
    task automatic model_edge();
        logic [31:0] w;
        bit done;
        done = 1'b0;
        w = 32'h0;
        if (reset) begin
            m_q.delete();
            m_bytes.delete();
            m_ptr  = 0;
            m_ovf  = 1'b0;
            m_idle = 0;
            return;
        end
        if (!cpu_req_i && m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_ptr = (m_ptr + 1) % RW;
        end
        if (rx_valid_i) begin
            m_idle = 0;
            m_bytes.push_back(rx_byte_i);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                done = 1'b1;
                m_bytes.delete();
            end
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        else if (m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TO) begin
                foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
                done = 1'b1;
                m_bytes.delete();
                m_idle = 0;
            end
        end
`endif
        if (done) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic req, input logic we, input logic [9:0] a,
                         input logic [31:0] d, input logic v, input logic [7:0] b);
        reset = r; cpu_req_i = req; cpu_we_i = we; cpu_addr_i = a;
        cpu_wdata_i = d; rx_valid_i = v; rx_byte_i = b;
        #1;
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
    endtask

    task automatic test_reset();
        mem_rdata_i = 32'h0;
        do_reset();
        checks++;
        if ({mem_we_o, wr_ptr_o, overflow_o, busy_o} !== {1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got we=%b ptr=%0d ovf=%b busy=%b, want 0/0/0/0", mem_we_o, wr_ptr_o, overflow_o, busy_o);
        end
        checks++;
        if (dut.state_r !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want IDLE", dut.state_r);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] b[4];
        b = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, b[i]);
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 10'h300, 32'h44332211}) begin
            errors++;
            $display("FAIL single_word: got we=%b addr=%h data=%h, want 1/300/44332211", mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        checks++;
        if ({wr_ptr_o, busy_o} !== {6'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_word_after: got ptr=%0d busy=%b, want 1/0", wr_ptr_o, busy_o);
        end
        checks++;
        if (dut.state_r !== DRAIN) begin
            errors++;
            $display("FAIL single_word_state: got %0d want DRAIN", dut.state_r);
        end
    endtask

    task automatic test_cpu_priority();
        int sent;
        logic v;
        logic [31:0] wd;
        sent = 0;
        do_reset();
        for (int cyc = 0; cyc < 100 && sent < 12; cyc++) begin
            v  = ($urandom_range(0, 3) != 0);
            wd = $urandom;
            drive(1'b0, 1'b1, 1'b1, 10'h010, wd, v, 8'($urandom));
            checks++;
            if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 10'h010, wd}) begin
                errors++;
                $display("FAIL cpu_priority cyc %0d: got we=%b addr=%h data=%h, want 1/010/%h", cyc, mem_we_o, mem_addr_o, mem_wdata_o, wd);
            end
            tick();
            if (v) sent++;
        end
        checks++;
        if (dut.state_r !== CPU) begin
            errors++;
            $display("FAIL cpu_state: got %0d want CPU", dut.state_r);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h010, 32'h0, 1'b0, 8'h00);
            checks++;
            if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 10'(10'h300 + k), e_wdata}) begin
                errors++;
                $display("FAIL cpu_release write %0d: got we=%b addr=%h data=%h, want 1/%h/%h", k, mem_we_o, mem_addr_o, mem_wdata_o, 10'(10'h300 + k), e_wdata);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h010, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({mem_we_o, busy_o, wr_ptr_o} !== {1'b0, 1'b0, 6'd3}) begin
            errors++;
            $display("FAIL cpu_release_done: got we=%b busy=%b ptr=%0d, want 0/0/3", mem_we_o, busy_o, wr_ptr_o);
        end
    endtask

    task automatic test_overflow();
        int writes;
        writes = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 10'h020, 32'h0, 1'b1, 8'(i + 1));
            tick();
        end
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %b want 1", overflow_o);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h020, 32'h0, 1'b0, 8'h00);
            if (mem_we_o === 1'b1) writes++;
            checks++;
            if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {e_we, e_addr, e_wdata}) begin
                errors++;
                $display("FAIL overflow_drain %0d: got we=%b addr=%h data=%h, want %b/%h/%h", i, mem_we_o, mem_addr_o, mem_wdata_o, e_we, e_addr, e_wdata);
            end
            tick();
        end
        checks++;
        if ({writes, overflow_o, wr_ptr_o} !== {32'd4, 1'b1, 6'd4}) begin
            errors++;
            $display("FAIL overflow_count: got writes=%0d ovf=%b ptr=%0d, want 4/1/4", writes, overflow_o, wr_ptr_o);
        end
    endtask

    task automatic test_wrap();
        int writes;
        bit wrote;
        writes = 0;
        do_reset();
        for (int w = 0; w < 65; w++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 8'(w * 4 + k));
                wrote = (mem_we_o === 1'b1);
                checks++;
                if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {e_we, e_addr, e_wdata}) begin
                    errors++;
                    $display("FAIL wrap word %0d byte %0d: got we=%b addr=%h data=%h, want %b/%h/%h", w, k, mem_we_o, mem_addr_o, mem_wdata_o, e_we, e_addr, e_wdata);
                end
                if (wrote) writes++;
                if (wrote && writes == 64) begin
                    checks++;
                    if (mem_addr_o !== 10'h33F) begin
                        errors++;
                        $display("FAIL wrap_64th_addr: got %h want 33f", mem_addr_o);
                    end
                end
                tick();
                if (wrote && writes == 64) begin
                    checks++;
                    if (wr_ptr_o !== 6'd0) begin
                        errors++;
                        $display("FAIL wrap_ptr: got %0d want 0", wr_ptr_o);
                    end
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({writes, mem_we_o, mem_addr_o} !== {32'd64, 1'b1, 10'h300}) begin
            errors++;
            $display("FAIL wrap_65th: got writes=%0d we=%b addr=%h, want 64/1/300", writes, mem_we_o, mem_addr_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b[4];
        b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 10'h040, 32'h0, 1'b1, 8'(i + 1));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 10'h040, 32'h0, 1'b0, 8'h00);
        checks++;
        if (mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: got we=%b want 0", mem_we_o);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h040, 32'h0, 1'b1, 8'(i + 5));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 10'h040, 32'h0, 1'b0, 8'h00);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h040, 32'h0, 1'b1, b[i]);
            checks++;
            if (mem_we_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_word_stale %0d: got we=%b want 0", i, mem_we_o);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h040, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 10'h300, 32'hDDCCBBAA}) begin
            errors++;
            $display("FAIL reset_mid_word: got we=%b addr=%h data=%h, want 1/300/ddccbbaa", mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 10'h040, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({mem_we_o, busy_o} !== {1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_word_after: got we=%b busy=%b, want 0/0", mem_we_o, busy_o);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b1, 8'h5A);
        tick();
`ifdef DMEM_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
            checks++;
            if (mem_we_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early %0d: got we=%b want 0", i, mem_we_o);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
        checks++;
        if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 10'h300, 32'h0000005A}) begin
            errors++;
            $display("FAIL timeout_flush: got we=%b addr=%h data=%h, want 1/300/0000005a", mem_we_o, mem_addr_o, mem_wdata_o);
        end
        tick();
`else
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 1'b0, 8'h00);
            checks++;
            if ({mem_we_o, busy_o} !== {1'b0, 1'b1}) begin
                errors++;
                $display("FAIL no_timeout %0d: got we=%b busy=%b, want 0/1", i, mem_we_o, busy_o);
            end
            tick();
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] rd;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rd = $urandom;
            mem_rdata_i = rd;
            drive(($urandom_range(0, 255) == 0), ($urandom_range(0, 2) == 0), 1'($urandom),
                  10'($urandom), $urandom, ($urandom_range(0, 1) == 0), 8'($urandom));
            checks++;
            if ({mem_we_o, mem_addr_o, mem_wdata_o, cpu_rdata_o} !== {e_we, e_addr, e_wdata, rd}) begin
                errors++;
                $display("FAIL random_port cyc %0d: got we=%b addr=%h data=%h rd=%h, want %b/%h/%h/%h", cyc, mem_we_o, mem_addr_o, mem_wdata_o, cpu_rdata_o, e_we, e_addr, e_wdata, rd);
            end
            checks++;
            if ({wr_ptr_o, overflow_o, busy_o} !== {6'(m_ptr), m_ovf, (m_bytes.size() > 0 || m_q.size() > 0)}) begin
                errors++;
                $display("FAIL random_status cyc %0d: got ptr=%0d ovf=%b busy=%b, want %0d/%b/%b", cyc, wr_ptr_o, overflow_o, busy_o, m_ptr, m_ovf, (m_bytes.size() > 0 || m_q.size() > 0));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_cpu_priority();
        test_overflow();
        test_wrap();
        test_reset_mid_word();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the ARM core and the UART receive path. The core always wins the port; received bytes are packed little-endian into 32-bit words, queued in a small FIFO, and written into a circular region of data memory on cycles the core leaves the port idle. Sits between the memory manager's data-memory outputs and the data memory, and is fed by the UART receiver's byte strobe.

## Interface
- ADDR_W, 10, data-memory word address width
- FIFO_DEPTH, 4, packed-word FIFO entries (power of two, ≥2)
- RING_BASE, 10'h300, first word address of the receive ring
- RING_WORDS, 64, ring length in words (power of two, ≤ 2^ADDR_W − RING_BASE)
- TIMEOUT, 1024, idle cycles before a partial word is flushed (macro only)

- clk  in  1  processor clock; all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req_i  in  1  core needs the port this cycle
- cpu_we_i  in  1  core write enable
- cpu_addr_i  in  ADDR_W  core word address
- cpu_wdata_i  in  32  core write data
- cpu_rdata_o  out  32  read data to core
- rx_valid_i  in  1  one-cycle strobe, byte valid
- rx_byte_i  in  8  received byte
- mem_we_o  out  1  data-memory write enable
- mem_addr_o  out  ADDR_W  data-memory address
- mem_wdata_o  out  32  data-memory write data
- mem_rdata_i  in  32  data-memory asynchronous read data
- wr_ptr_o  out  $clog2(RING_WORDS)  next ring index to be written
- overflow_o  out  1  sticky: a packed word was dropped
- busy_o  out  1  packer or FIFO holds unwritten data

## Operation
- Packer: byte counter 0..3 plus 24-bit holding register. Byte n lands in bits [8n+7:8n]. On the 4th strobe the complete word is pushed to the FIFO at that edge; counter returns to 0.
- Arbiter FSM, states IDLE, CPU, DRAIN, registered each cycle from the current inputs:
  - CPU when cpu_req_i=1, regardless of FIFO.
  - DRAIN when cpu_req_i=0 and FIFO not empty.
  - IDLE otherwise.
- Port mux is combinational from cpu_req_i and FIFO empty, not from the registered state. The state is for observation and coverage only.
  - Core owns port: mem_we_o=cpu_we_i, mem_addr_o=cpu_addr_i, mem_wdata_o=cpu_wdata_i.
  - Drain: mem_we_o=1, mem_addr_o=RING_BASE+wr_ptr, mem_wdata_o=FIFO head. Pop and wr_ptr+1 at the edge.
  - Idle: mem_we_o=0, addr/wdata = core inputs.
- cpu_rdata_o = mem_rdata_i at all times.
- wr_ptr wraps RING_WORDS−1 → 0. No read pointer; the core tracks consumption via wr_ptr_o. The ring overwrites silently.
- FIFO full and a word completes with no pop that cycle: word dropped, overflow_o←1 until reset. Full with simultaneous push and pop: both happen, no overflow.
- Byte strobe on a drain cycle: packer and FIFO updates are independent. Push and pop in the same cycle are legal at any occupancy.
- busy_o = (byte count ≠ 0) | FIFO not empty.

## Timing
- Reset values: mem_we_o=0 when cpu_req_i=0; wr_ptr_o=0; overflow_o=0; busy_o=0; FSM=IDLE; packer and FIFO empty.
- Reset mid-word or mid-drain discards all buffered data. No write is issued in the reset cycle unless the core requests one.
- Latency from 4th strobe to ring write: 1 cycle minimum (push at edge N, write during cycle N+1 if cpu_req_i=0). Each further cycle with cpu_req_i held high adds 1 cycle.
- Sustained drain rate: one word per free cycle.
- Core access: zero added latency, purely combinational path.

## Configuration
- DMEM_ARB_TIMEOUT_EN defined:
  - Counter runs while the packer holds 1–3 bytes and rx_valid_i=0. Any strobe clears it.
  - At TIMEOUT it pushes the partial word zero-padded in the upper bytes, clears the packer, and follows the same overflow rule as a full word.
- Undefined: partial bytes wait indefinitely; no counter logic is synthesized.

## Structure
- Package dmem_arb_pkg: arb_state_t enum (IDLE, CPU, DRAIN), default RING_BASE/RING_WORDS/TIMEOUT constants, byte-lane helper localparams.
- Sub-module dmem_arb_fifo: synchronous FIFO, FIFO_DEPTH×32, show-ahead head, push/pop/full/empty, simultaneous push+pop legal when full.

## Test plan
- Reset, then strobe 8'h11,22,33,44 with cpu_req_i=0 → next cycle mem_we_o=1, mem_addr_o=10'h300, mem_wdata_o=32'h44332211; wr_ptr_o=1; busy_o=0.
- Hold cpu_req_i=1 with cpu_we_i=1, addr 10'h010, while 3 words arrive → every cycle the port shows the core access. On release, 3 consecutive ring writes to 10'h300–302.
- Keep cpu_req_i=1 and push 5 words (FIFO_DEPTH=4) → 5th dropped, overflow_o=1 and stays 1. After release exactly 4 writes occur.
- Drive 64 words with idle port → 64th write at 10'h33F, wr_ptr_o=0; 65th word written at 10'h300.
- Send 2 bytes, assert reset one cycle, send 4 bytes 8'hAA..DD → single write 32'hDDCCBBAA. No stale bytes appear.
- With DMEM_ARB_TIMEOUT_EN and TIMEOUT=16: send 8'h5A, idle 16 cycles → write 32'h0000005A. Without the macro → no write, busy_o stays 1.
